// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared constants and state type for the nibble-serial CLA adder
package cla_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

endpackage

// File: rtl/carry_lookahead_adder_4bit.sv
// rtl/carry_lookahead_adder_4bit.sv - 4-bit carry lookahead slice, combinational sum and carry
module carry_lookahead_adder_4bit (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       done
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:1] c;

   assign g = a & b;
   assign p = a ^ b;

   // every carry is formed directly from generate/propagate terms, no ripple
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ {c[3], c[2], c[1], cin};
   assign cout = c[4];

   // flags the slice as usable from the first cycle after reset is released
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
      end else begin
         done <= 1'b1;
      end
   end

endmodule

// File: rtl/cla_nibble_sequencer.sv
// rtl/cla_nibble_sequencer.sv - multi-cycle adder over one shared CLA slice; CLA_SEQ_SUB_EN adds op_sub
module cla_nibble_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
   input  logic             op_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   cla_seq_state_t   state;
   cla_seq_state_t   state_nxt;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             accept;
   logic [3:0]       slice_sum;
   logic             slice_cout;
   logic             slice_done_unused;

`ifdef CLA_SEQ_SUB_EN
   // subtraction is a + ~b + 1; cin has no meaning then
   assign b_eff   = op_sub ? ~b : b;
   assign cin_eff = op_sub | cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN);

   carry_lookahead_adder_4bit u_slice (
      .clk   (clk),
      .reset (reset),
      .a     (a_reg[NIBBLE_W*idx +: NIBBLE_W]),
      .b     (b_reg[NIBBLE_W*idx +: NIBBLE_W]),
      .cin   (carry),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .done  (slice_done_unused)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN:  if (idx == LAST_IDX) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx   <= '0;
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b_eff;
         carry <= cin_eff;
         idx   <= '0;
      end else if (state == RUN) begin
         sum[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
         carry <= slice_cout;
         if (idx == LAST_IDX) begin
            idx  <= '0;
            cout <= slice_cout;
            // slice_sum[3] is the MSB of the final sum on the last pass
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (slice_sum[3] != a_reg[WIDTH-1]);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb/tb_cla_nibble_sequencer.sv - scoreboard bench for cla_nibble_sequencer against an arithmetic model
module tb_cla_nibble_sequencer;

   localparam int W   = 32;
   localparam int NIB = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic         cin = 1'b0;
   logic         op_sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] sum;
   logic         in_ready;
   logic         out_valid;
   logic         cout;
   logic         ovf;
   logic         busy;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   issued = 0;
   int   accepts = 0;
   bit   stim_done = 0;
   bit   drv_to = 0;
   bit   manual = 1;
   logic manual_val = 1'b1;

   cla_nibble_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
      .op_sub    (op_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = manual ? manual_val : ($urandom_range(3) != 0);
   end

   function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sub, int acc);
      exp_t         e;
      logic [W-1:0] be;
      logic         c;
      logic [W:0]   full;
      longint       s;
      be   = sub ? ~y : y;
      c    = sub ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, c};
      s    = longint'($signed(x)) + longint'($signed(be)) + longint'(c);
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.acc  = acc;
      return e;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sub, bit hold);
      int n;
      n = 0;
      @(posedge clk);
      #2;
      a = x; b = y; cin = ci; op_sub = sub; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         drv_to = 1;
         in_valid = 1'b0;
         return;
      end
      q.push_back(model(x, y, ci, sub, cyc + 1));
      issued++;
      @(posedge clk);
      #2;
      if (hold) begin
         repeat (NIB - 2) begin
            a = $urandom; b = $urandom; cin = 1'($urandom);
            @(posedge clk);
            #2;
         end
      end
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      logic sub;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;

      issue(32'h0000_000F, 32'h1, 1'b0, 1'b0, 0);
      issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
      issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
      drain();

      // result held under backpressure, then handoff and accept in the same cycle
      manual_val = 1'b0;
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      manual_val = 1'b1;
      issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, 0);
      drain();

      // abort at idx==3
      issue(32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);
      drain();

      issue($urandom, $urandom, 1'b0, 1'b0, 1);
      drain();

`ifdef CLA_SEQ_SUB_EN
      issue(32'd5, 32'd7, 1'b0, 1'b1, 0);
      issue(32'd7, 32'd5, 1'b1, 1'b1, 0);
      drain();
`endif

      manual = 0;
      for (int i = 0; i < 40; i++) begin
`ifdef CLA_SEQ_SUB_EN
         sub = 1'($urandom);
`else
         sub = 1'b0;
`endif
         issue($urandom, $urandom, 1'($urandom), sub, ($urandom_range(3) == 0));
      end
      manual_val = 1'b1;
      manual = 1;
      drain();
      stim_done = 1;
   end

   initial begin
      bit seen;
      bit low_next;
      bit bexp;
      seen = 0;
      low_next = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("reset_out_valid", out_valid, 0);
            check("reset_in_ready", in_ready, 1);
            check("reset_sum", sum, 0);
            check("reset_cout", cout, 0);
            check("reset_ovf", ovf, 0);
            q.delete();
            seen = 0;
            low_next = 0;
         end else begin
            if (in_valid && in_ready) accepts++;
            if (low_next) begin
               check("valid_after_handoff", out_valid, 0);
               low_next = 0;
            end
            if (out_valid) begin
               check("result_expected", q.size() != 0, 1);
               if (q.size() != 0) begin
                  if (!seen) begin
                     check("latency", cyc - q[0].acc, NIB);
                     seen = 1;
                  end
                  check("sum", sum, q[0].sum);
                  check("cout", cout, q[0].cout);
                  check("ovf", ovf, q[0].ovf);
                  check("in_ready_done", in_ready, out_ready);
                  if (out_ready) begin
                     void'(q.pop_front());
                     seen = 0;
                     low_next = 1;
                  end
               end
            end else begin
               bexp = (q.size() != 0) && (cyc >= q[0].acc);
               check("busy", busy, bexp);
               check("in_ready_idle", in_ready, !bexp);
            end
         end
         if (stim_done && q.size() == 0) break;
         if (cyc > 50000) begin
            errors++;
            $display("FAIL timeout actual=%0d cycles expected=completion", cyc);
            break;
         end
      end
      check("accept_count", accepts, issued);
      check("driver_wait", drv_to, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
